sram_2rw_param: RTL and testbench



---
 rtl/sram_pkg.sv | 43 ++++
 rtl/sram_rd_pipe.sv | 59 +++++
 rtl/sram_2rw_param.sv | 144 ++++++++++++++
 tb/tb_sram_2rw_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the parametrised two-port SRAM.
//   state_t      - controller state (INIT = post-reset clear sweep, RUN = serving requests)
//   depth_of     - word count for a given address width
//   mask_w_of    - byte-mask width for a given data width
//   merge_byte   - resolves one byte of a masked write with a priority port
//   ADDR_W_DEF / DATA_W_DEF and the derived DEPTH / MASK_W describe the default macro.
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int mask_w_of(input int data_w);
    return data_w / 8;
  endfunction

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH      = depth_of(ADDR_W_DEF);
  localparam int MASK_W     = mask_w_of(DATA_W_DEF);

  // The high-priority source owns the byte whenever it is enabled; the
  // low-priority source only fills bytes the other one left alone.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] hi_b,
    input logic       hi_en,
    input logic [7:0] lo_b,
    input logic       lo_en
  );
    logic [7:0] res;
    res = old_b;
    if (hi_en)      res = hi_b;
    else if (lo_en) res = lo_b;
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: read data capture and valid pipeline for one SRAM port.
//   clock, reset_n - clock and asynchronous active-low reset
//   rd_en          - a read was accepted this cycle
//   rd_word        - memory word at the read address (pre-write value)
//   rdata, rvalid  - read data (held between reads) and one-cycle valid strobe
// OUT_REG = 0 gives one cycle of latency, OUT_REG = 1 adds a second register.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_REG = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;

  // Stage p0: capture on acceptance, hold otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= rd_en;
      if (rd_en) data_p0 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] data_p1;
      logic              vld_p1;

      // Stage p1: optional output register
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign rdata  = data_p1;
      assign rvalid = vld_p1;
    end else begin : g_direct
      assign rdata  = data_p0;
      assign rvalid = vld_p0;
    end
  endgenerate

endmodule

// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised two read/write port synchronous SRAM with
// byte masks, read-first collision handling and an optional clear sweep.
//   clock, reset_n         - sole clock, asynchronous active-low reset
//   ready                  - requests are accepted (controller in RUN)
//   collision              - registered pulse: same-address pair, at least one write
//   en/we/wmask/addr/wdata - per-port request (1 and 2)
//   rdata, rvalid          - per-port read data and valid strobe
// Port 1 has byte priority on write/write collisions; reads always see the
// word as it was before this cycle's writes.
module sram_2rw_param
  import sram_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                ready,
  output logic                collision,
  input  logic                en1,
  input  logic                we1,
  input  logic [DATA_W/8-1:0] wmask1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                rvalid1,
  input  logic                en2,
  input  logic                we2,
  input  logic [DATA_W/8-1:0] wmask2,
  input  logic [ADDR_W-1:0]   addr2,
  input  logic [DATA_W-1:0]   wdata2,
  output logic [DATA_W-1:0]   rdata2,
  output logic                rvalid2
);

  localparam int     MEM_DEPTH  = depth_of(ADDR_W);
  localparam int     BYTES      = mask_w_of(DATA_W);
  localparam int     SWEEP_LAST = MEM_DEPTH / 2 - 1;
  localparam state_t RESET_ST   = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0] sweep_even, sweep_odd;
  logic              ready_q, coll_q, coll_d;
  logic              sweep_we;

  logic              acc_rd1, acc_wr1, acc_rd2, acc_wr2, same_addr;
  logic [DATA_W-1:0] old1, old2, new1, new2;

  // Controller next state: the sweep clears two words per cycle
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    sweep_we = 1'b0;
    if (state_q == ST_INIT) begin
      sweep_we = 1'b1;
      if (sweep_q == ADDR_W'(SWEEP_LAST)) state_d = ST_RUN;
      else                                sweep_d = sweep_q + ADDR_W'(1);
    end
  end

  assign sweep_even = sweep_q << 1;
  assign sweep_odd  = sweep_even | ADDR_W'(1);

  // Requests are only honoured once ready has been registered high, so the
  // cycle that finishes the sweep (or leaves reset) never accepts anything.
  assign acc_rd1   = ready_q & en1 & ~we1;
  assign acc_wr1   = ready_q & en1 &  we1;
  assign acc_rd2   = ready_q & en2 & ~we2;
  assign acc_wr2   = ready_q & en2 &  we2;
  assign same_addr = (addr1 == addr2);
  assign coll_d    = ready_q & en1 & en2 & same_addr & (we1 | we2);

  // Control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_ST;
      sweep_q <= '0;
      ready_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= (state_d == ST_RUN);
      coll_q  <= coll_d;
    end
  end

  assign ready     = ready_q;
  assign collision = coll_q;

  // Pre-write words; these feed both the read pipes and the byte merge.
  assign old1 = mem[addr1];
  assign old2 = mem[addr2];

  // When both ports write one word, both merged words come out identical,
  // so the two array writes below agree.
  always_comb begin
    new1 = old1;
    new2 = old2;
    for (int b = 0; b < BYTES; b++) begin
      new1[8*b +: 8] = merge_byte(old1[8*b +: 8],
                                  wdata1[8*b +: 8], acc_wr1 & wmask1[b],
                                  wdata2[8*b +: 8], acc_wr2 & wmask2[b] & same_addr);
      new2[8*b +: 8] = merge_byte(old2[8*b +: 8],
                                  wdata1[8*b +: 8], acc_wr1 & wmask1[b] & same_addr,
                                  wdata2[8*b +: 8], acc_wr2 & wmask2[b]);
    end
  end

  // Array storage: contents survive reset unless the sweep clears them
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[sweep_even] <= '0;
      mem[sweep_odd]  <= '0;
    end else begin
      if (acc_wr1) mem[addr1] <= new1;
      if (acc_wr2) mem[addr2] <= new2;
    end
  end

  sram_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_pipe1 (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_en   (acc_rd1),
    .rd_word (old1),
    .rdata   (rdata1),
    .rvalid  (rvalid1)
  );

  sram_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rd_pipe2 (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_en   (acc_rd2),
    .rd_word (old2),
    .rdata   (rdata2),
    .rvalid  (rvalid2)
  );

endmodule

// File: tb/tb_sram_2rw_param.sv
// tb_sram_2rw_param: bench for sram_2rw_param. Three instances share one clock:
// default parameters (A), OUT_REG = 1 (B, same stimulus as A) and
// CLEAR_ON_RESET = 0 (C, port 1 only).
module tb_sram_2rw_param;
  import sram_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en1, we1, en2, we2;
  logic [3:0]  wmask1, wmask2;
  logic [5:0]  addr1, addr2;
  logic [31:0] wdata1, wdata2;

  logic        a_ready, a_coll, a_rvalid1, a_rvalid2;
  logic [31:0] a_rdata1, a_rdata2;
  logic        b_ready, b_coll, b_rvalid1, b_rvalid2;
  logic [31:0] b_rdata1, b_rdata2;

  logic        c_rst_n, c_en1, c_we1;
  logic [5:0]  c_addr1;
  logic [31:0] c_wdata1;
  logic        c_ready, c_coll, c_rvalid1, c_rvalid2;
  logic [31:0] c_rdata1, c_rdata2;

  sram_2rw_param u_a (
    .clock(clk), .reset_n(rst_n), .ready(a_ready), .collision(a_coll),
    .en1(en1), .we1(we1), .wmask1(wmask1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(a_rdata1), .rvalid1(a_rvalid1),
    .en2(en2), .we2(we2), .wmask2(wmask2), .addr2(addr2), .wdata2(wdata2),
    .rdata2(a_rdata2), .rvalid2(a_rvalid2)
  );

  sram_2rw_param #(.OUT_REG(1)) u_b (
    .clock(clk), .reset_n(rst_n), .ready(b_ready), .collision(b_coll),
    .en1(en1), .we1(we1), .wmask1(wmask1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(b_rdata1), .rvalid1(b_rvalid1),
    .en2(en2), .we2(we2), .wmask2(wmask2), .addr2(addr2), .wdata2(wdata2),
    .rdata2(b_rdata2), .rvalid2(b_rvalid2)
  );

  sram_2rw_param #(.CLEAR_ON_RESET(0)) u_c (
    .clock(clk), .reset_n(c_rst_n), .ready(c_ready), .collision(c_coll),
    .en1(c_en1), .we1(c_we1), .wmask1(4'hF), .addr1(c_addr1), .wdata1(c_wdata1),
    .rdata1(c_rdata1), .rvalid1(c_rvalid1),
    .en2(1'b0), .we2(1'b0), .wmask2(4'h0), .addr2(6'd0), .wdata2(32'h0),
    .rdata2(c_rdata2), .rvalid2(c_rvalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word array plus expected outputs of A and B.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] ea_rd1, ea_rd2, eb_rd1, eb_rd2;
  logic        ea_v1, ea_v2, eb_v1, eb_v2, e_coll, m_ready;
  int          m_sweep;

  task automatic model_reset();
    ea_rd1 = '0; ea_rd2 = '0; eb_rd1 = '0; eb_rd2 = '0;
    ea_v1 = 0; ea_v2 = 0; eb_v1 = 0; eb_v2 = 0; e_coll = 0;
    m_ready = 0;
    m_sweep = DEPTH / 2;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic idle_inputs();
    en1 = 0; we1 = 0; wmask1 = '0; addr1 = '0; wdata1 = '0;
    en2 = 0; we2 = 0; wmask2 = '0; addr2 = '0; wdata2 = '0;
  endtask

  // One clock of A/B: predict from the current inputs, clock, then compare.
  task automatic step();
    logic a1r, a2r, a1w, a2w;
    eb_v1 = ea_v1; if (ea_v1) eb_rd1 = ea_rd1;
    eb_v2 = ea_v2; if (ea_v2) eb_rd2 = ea_rd2;
    a1r = m_ready & en1 & ~we1;
    a1w = m_ready & en1 &  we1;
    a2r = m_ready & en2 & ~we2;
    a2w = m_ready & en2 &  we2;
    ea_v1 = a1r; if (a1r) ea_rd1 = model_mem[addr1];
    ea_v2 = a2r; if (a2r) ea_rd2 = model_mem[addr2];
    e_coll = m_ready & en1 & en2 & (addr1 == addr2) & (we1 | we2);
    // port 2 first, then port 1 so its enabled bytes take precedence
    for (int b = 0; b < MASK_W; b++)
      if (a2w && wmask2[b]) model_mem[addr2][8*b +: 8] = wdata2[8*b +: 8];
    for (int b = 0; b < MASK_W; b++)
      if (a1w && wmask1[b]) model_mem[addr1][8*b +: 8] = wdata1[8*b +: 8];
    @(posedge clk); #1;
    if (m_sweep > 0) m_sweep--;
    m_ready = (m_sweep == 0);
    chk("a_ready",   32'(a_ready),   32'(m_ready));
    chk("a_coll",    32'(a_coll),    32'(e_coll));
    chk("a_rvalid1", 32'(a_rvalid1), 32'(ea_v1));
    chk("a_rvalid2", 32'(a_rvalid2), 32'(ea_v2));
    chk("a_rdata1",  a_rdata1,       ea_rd1);
    chk("a_rdata2",  a_rdata2,       ea_rd2);
    chk("b_rvalid1", 32'(b_rvalid1), 32'(eb_v1));
    chk("b_rvalid2", 32'(b_rvalid2), 32'(eb_v2));
    chk("b_rdata1",  b_rdata1,       eb_rd1);
    chk("b_rdata2",  b_rdata2,       eb_rd2);
  endtask

  task automatic check_outputs_cleared(input string tag);
    chk({tag, "_a_ready"},   32'(a_ready),   0);
    chk({tag, "_a_coll"},    32'(a_coll),    0);
    chk({tag, "_a_rvalid1"}, 32'(a_rvalid1), 0);
    chk({tag, "_a_rdata1"},  a_rdata1,       0);
    chk({tag, "_a_rdata2"},  a_rdata2,       0);
    chk({tag, "_b_rvalid1"}, 32'(b_rvalid1), 0);
    chk({tag, "_b_rdata1"},  b_rdata1,       0);
    chk({tag, "_b_ready"},   32'(b_ready),   0);
  endtask

  // Count edges from release until ready goes high (bounded).
  task automatic sweep_count(input string name, input bit check_c);
    int first;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (check_c && i == 1) chk("c_ready_first_edge", 32'(c_ready), 1);
      if (first == 0 && a_ready) first = i;
    end
    chk(name, first, DEPTH / 2);
  endtask

  task automatic read_all_words();
    for (int i = 0; i < DEPTH; i++) begin
      en1 = 1; we1 = 0; addr1 = 6'(i);
      en2 = 1; we2 = 0; addr2 = 6'(DEPTH - 1 - i);
      step();
    end
    idle_inputs();
    step();
  endtask

  typedef struct {
    logic en1; logic we1; logic [3:0] m1; logic [5:0] a1; logic [31:0] d1;
    logic en2; logic we2; logic [3:0] m2; logic [5:0] a2; logic [31:0] d2;
    logic [31:0] r1; logic v1; logic [31:0] r2; logic v2; logic c;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // expected outputs A shows one edge after each row is presented
    tbl[0]  = '{1,1,4'hF,6'd5, 32'hDEADBEEF, 0,0,4'h0,6'd0, 32'h0,        32'h0,        0, 32'h0,        0, 0};
    tbl[1]  = '{0,0,4'h0,6'd0, 32'h0,        1,0,4'h0,6'd5, 32'h0,        32'h0,        0, 32'hDEADBEEF, 1, 0};
    tbl[2]  = '{1,1,4'h3,6'd9, 32'h11111111, 1,1,4'hF,6'd9, 32'h22222222, 32'h0,        0, 32'hDEADBEEF, 0, 1};
    tbl[3]  = '{1,0,4'h0,6'd9, 32'h0,        0,0,4'h0,6'd0, 32'h0,        32'h22221111, 1, 32'hDEADBEEF, 0, 0};
    tbl[4]  = '{1,1,4'hF,6'd3, 32'hA5A5A5A5, 0,0,4'h0,6'd0, 32'h0,        32'h22221111, 0, 32'hDEADBEEF, 0, 0};
    tbl[5]  = '{1,1,4'hF,6'd3, 32'h5A5A5A5A, 1,0,4'h0,6'd3, 32'h0,        32'h22221111, 0, 32'hA5A5A5A5, 1, 1};
    tbl[6]  = '{0,0,4'h0,6'd0, 32'h0,        1,0,4'h0,6'd3, 32'h0,        32'h22221111, 0, 32'h5A5A5A5A, 1, 0};
    tbl[7]  = '{1,0,4'h0,6'd3, 32'h0,        1,0,4'h0,6'd3, 32'h0,        32'h5A5A5A5A, 1, 32'h5A5A5A5A, 1, 0};
    tbl[8]  = '{1,1,4'h0,6'd7, 32'hFFFFFFFF, 1,0,4'h0,6'd7, 32'h0,        32'h5A5A5A5A, 0, 32'h0,        1, 1};
    tbl[9]  = '{1,0,4'h0,6'd7, 32'h0,        1,1,4'h5,6'd63,32'hAABBCCDD, 32'h0,        1, 32'h0,        0, 0};
    tbl[10] = '{1,0,4'h0,6'd0, 32'h0,        1,0,4'h0,6'd63,32'h0,        32'h0,        1, 32'h00BB00DD, 1, 0};
    tbl[11] = '{1,0,4'h0,6'd63,32'h0,        1,1,4'hF,6'd63,32'h01020304, 32'h00BB00DD, 1, 32'h00BB00DD, 0, 1};
    tbl[12] = '{1,0,4'h0,6'd63,32'h0,        0,0,4'h0,6'd0, 32'h0,        32'h01020304, 1, 32'h00BB00DD, 0, 0};

    idle_inputs();
    c_en1 = 0; c_we1 = 0; c_addr1 = '0; c_wdata1 = '0;
    rst_n = 1; c_rst_n = 1;
    #2;
    rst_n = 0; c_rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outputs_cleared("reset");
    chk("reset_c_ready", 32'(c_ready), 0);

    // release: A/B sweep, C ready at once
    rst_n = 1; c_rst_n = 1;
    sweep_count("sweep_len_first", 1'b1);
    read_all_words();

    // directed vectors
    for (int i = 0; i < 13; i++) begin
      en1 = tbl[i].en1; we1 = tbl[i].we1; wmask1 = tbl[i].m1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      en2 = tbl[i].en2; we2 = tbl[i].we2; wmask2 = tbl[i].m2; addr2 = tbl[i].a2; wdata2 = tbl[i].d2;
      step();
      chk($sformatf("tbl%0d_rdata1", i),  a_rdata1,        tbl[i].r1);
      chk($sformatf("tbl%0d_rvalid1", i), 32'(a_rvalid1),  32'(tbl[i].v1));
      chk($sformatf("tbl%0d_rdata2", i),  a_rdata2,        tbl[i].r2);
      chk($sformatf("tbl%0d_rvalid2", i), 32'(a_rvalid2),  32'(tbl[i].v2));
      chk($sformatf("tbl%0d_coll", i),    32'(a_coll),     32'(tbl[i].c));
    end
    idle_inputs();
    step();

    // random traffic, biased toward a few addresses to force collisions
    for (int n = 0; n < 600; n++) begin
      en1 = ($urandom_range(0, 3) != 0); we1 = $urandom_range(0, 1) == 1;
      en2 = ($urandom_range(0, 3) != 0); we2 = $urandom_range(0, 1) == 1;
      wmask1 = 4'($urandom); wmask2 = 4'($urandom);
      wdata1 = $urandom; wdata2 = $urandom;
      addr1 = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      addr2 = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      step();
    end
    // make sure the top words are dirty before the sweep test
    en1 = 1; we1 = 1; wmask1 = 4'hF; addr1 = 6'd62; wdata1 = 32'hCAFEF00D;
    en2 = 1; we2 = 1; wmask2 = 4'hF; addr2 = 6'd33; wdata2 = 32'h0BADC0DE;
    step();

    // reset with reads in flight in both instances
    en1 = 1; we1 = 0; addr1 = 6'd62; en2 = 1; we2 = 0; addr2 = 6'd33;
    step();
    chk("inflight_a_rdata1", a_rdata1, 32'hCAFEF00D);
    idle_inputs();
    #1 rst_n = 0;
    model_reset();
    #1;
    check_outputs_cleared("midread");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    // read requests during the sweep must be ignored
    en1 = 1; addr1 = 6'd62; en2 = 1; addr2 = 6'd33;
    for (int i = 0; i < 10; i++) step();
    idle_inputs();

    // reset again mid-sweep; the sweep must restart from word 0
    rst_n = 0;
    model_reset();
    #1;
    check_outputs_cleared("midsweep");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    sweep_count("sweep_len_restart", 1'b0);
    read_all_words();

    // C: contents survive reset when the sweep is disabled
    c_en1 = 1; c_we1 = 1; c_addr1 = 6'd63; c_wdata1 = 32'h12345678;
    @(posedge clk); #1;
    c_en1 = 0; c_we1 = 0;
    c_rst_n = 0;
    #1;
    chk("c_ready_in_reset", 32'(c_ready), 0);
    chk("c_rdata1_in_reset", c_rdata1, 0);
    @(posedge clk); @(posedge clk); #1;
    c_rst_n = 1;
    @(posedge clk); #1;
    chk("c_ready_after_release", 32'(c_ready), 1);
    c_en1 = 1; c_we1 = 0; c_addr1 = 6'd63;
    @(posedge clk); #1;
    c_en1 = 0;
    chk("c_rdata1_kept", c_rdata1, 32'h12345678);
    chk("c_rvalid1", 32'(c_rvalid1), 1);
    @(posedge clk); #1;
    chk("c_rvalid1_pulse", 32'(c_rvalid1), 0);
    chk("c_rdata1_hold", c_rdata1, 32'h12345678);
    chk("c_rvalid2", 32'(c_rvalid2), 0);
    chk("c_rdata2", c_rdata2, 0);
    chk("c_coll", 32'(c_coll), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
